pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the falling edge, like the other pipeline stage registers.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset; reset==0 clears state immediately, independent of clk.
REQ-004 SHALL have port StallF  input  1  hazard-unit request to freeze the fetch stage.
REQ-005 SHALL have port RedirectF  input  1  taken branch or jump from a later stage.
REQ-006 SHALL have port RedirectPC  input  32  target PC for RedirectF.
REQ-007 SHALL have port imem_ready  input  1  instruction memory has returned the word at imem_addr this cycle.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  output  32  fetch address, equal to PCF.
REQ-010 SHALL have port PCF  output  32  current fetch PC.
REQ-011 SHALL have port PCPlus4F  output  32  PCF+4, the first stage of the PC+4 pipeline chain toward the decode, execute and memory registers.
REQ-012 SHALL have port validF  output  1  registered flag: the previous edge completed a fetch that downstream consumes.
REQ-013 SHALL have port fault  output  1  sticky misaligned-redirect flag; present in both builds.

Function
REQ-014 SHALL implement the states BOOT, FETCH, HOLD and FAULT.
REQ-015 BOOT SHALL drive imem_req=0 and validF=0, and SHALL move to FETCH on the first falling edge after reset release.
REQ-016 FETCH SHALL drive imem_req=1 with imem_addr=PCF.
REQ-017 FETCH, RedirectF=1 (highest priority, overrides StallF and imem_ready) SHALL load PCF<=RedirectPC and validF<=0, stay in FETCH, and discard any concurrent response.
REQ-018 FETCH, imem_ready=0 SHALL hold PCF and set validF<=0.
REQ-019 FETCH, imem_ready=1, StallF=0 SHALL load PCF<=PCF+4 and validF<=1.
REQ-020 FETCH, imem_ready=1, StallF=1 SHALL hold PCF, set validF<=0 and move to HOLD.
REQ-021 HOLD SHALL drive imem_req=0 and hold PCF.
REQ-022 HOLD, RedirectF=1 SHALL load PCF<=RedirectPC and validF<=0, and move to FETCH.
REQ-023 HOLD, StallF=0 SHALL load PCF<=PCF+4 and validF<=1, and move to FETCH.
REQ-024 HOLD, StallF=1 SHALL remain in HOLD with validF=0.
REQ-025 PCPlus4F SHALL be combinational PCF+4, modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-026 The PC increment SHALL wrap modulo 2^32 with no flag raised.
REQ-027 StallF=1 in FETCH with imem_ready=0 SHALL behave as REQ-018 (no state change).

Reset
REQ-028 While reset==0 the block SHALL force state=BOOT, PCF=RESET_PC, validF=0, fault=0 and imem_req=0.
REQ-029 Reset asserted mid-fetch or in HOLD SHALL abandon the outstanding request; no validF pulse SHALL follow reset release before the first completed fetch.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN defined: a redirect with RedirectPC[1:0]!=0 SHALL set fault<=1 and enter FAULT.
REQ-031 FAULT (with PC_ALIGN_CHECK_EN defined) SHALL drive imem_req=0 and validF=0 and hold PCF until reset.
REQ-032 Macro PC_ALIGN_CHECK_EN undefined: the block SHALL load RedirectPC with bits [1:0] forced to 00, tie fault to 0, and SHALL have no FAULT state.

Verification
REQ-033 Reset release with imem_ready=1 held -> one cycle in BOOT, then PCF sequence 0,4,8,C, with validF=1 from the second FETCH edge.
REQ-034 imem_ready low for 3 cycles at PCF=8 -> PCF stays 8 and validF=0 for 3 edges, then PCF=C with validF=1.
REQ-035 StallF=1 coincident with imem_ready=1 at PCF=10 -> HOLD and imem_req=0; StallF released 2 cycles later -> PCF=14, validF=1.
REQ-036 RedirectF=1 with RedirectPC=0x400 concurrent with StallF=1 and imem_ready=1 -> PCF=0x400 and validF=0 on the next edge.
REQ-037 RESET_PC=32'hFFFFFFFC -> PCPlus4F=0, and the next PCF=0.
REQ-038 RedirectPC=0x402 -> with PC_ALIGN_CHECK_EN defined: fault=1 and imem_req=0 until reset; with it undefined: PCF=0x400 and fault=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch-stage PC register and instruction-memory request sequencer.
// Ports: clk/reset, StallF/RedirectF/RedirectPC, imem_ready in; imem_req, imem_addr, PCF, PCPlus4F, validF, fault out. Option: PC_ALIGN_CHECK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectF,
  input  logic [31:0] RedirectPC,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF,
  output logic        fault
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] redir_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign redir_pc = RedirectPC;
  assign fault    = fault_q;
`else
  // Without the check, a misaligned target is silently word-aligned.
  assign redir_pc = RedirectPC & ~32'h3;
  assign fault    = 1'b0;
`endif

  assign PCPlus4F  = PCF + 32'd4;
  assign imem_addr = PCF;
  assign imem_req  = (state == FETCH);

  always_comb begin
    state_d = state;
    pc_d    = PCF;
    valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state)
      BOOT: state_d = FETCH;
      FETCH, HOLD: begin
        if (RedirectF) begin
`ifdef PC_ALIGN_CHECK_EN
          if (|RedirectPC[1:0]) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else
`endif
          begin
            pc_d    = redir_pc;
            state_d = FETCH;
          end
        end else if (state == FETCH) begin
          // A response arriving under stall is held; the
          // PC advances when HOLD is released.
          if (imem_ready) begin
            if (StallF) begin
              state_d = HOLD;
            end else begin
              pc_d    = PCPlus4F;
              valid_d = 1'b1;
            end
          end
        end else if (!StallF) begin
          pc_d    = PCPlus4F;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state  <= BOOT;
      PCF    <= RESET_PC;
      validF <= 1'b0;
    end else begin
      state  <= state_d;
      PCF    <= pc_d;
      validF <= valid_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: boot, stalls, redirects, reset, wrap, alignment.
// The DUT updates on the falling edge; outputs are sampled 1 time unit after it.
module tb_pc_fetch;
  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        RedirectF = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        imem_ready = 1'b1;
  logic        imem_req, validF, fault;
  logic [31:0] imem_addr, PCF, PCPlus4F;
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_pc, w_pc4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .reset(reset), .StallF(StallF), .RedirectF(RedirectF),
    .RedirectPC(RedirectPC), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .validF(validF), .fault(fault)
  );

  pc_fetch #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .reset(reset), .StallF(StallF), .RedirectF(RedirectF),
    .RedirectPC(RedirectPC), .imem_ready(imem_ready), .imem_req(w_req),
    .imem_addr(w_addr), .PCF(w_pc), .PCPlus4F(w_pc4),
    .validF(w_valid), .fault(w_fault)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PCF, 32'h0); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", validF); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h want %h", PCPlus4F, 32'h4); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", imem_req); end
  endtask

  task automatic test_boot_seq();
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", validF); end
    tick();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL boot_fetch_pc: got %h want %h", PCF, 32'h0); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL boot_fetch_valid: got %b want 0", validF); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_fetch_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_fetch_addr: got %h want %h", imem_addr, 32'h0); end
    tick();
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want %h", PCF, 32'h4); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL seq_valid4: got %b want 1", validF); end
    tick();
    checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h want %h", PCF, 32'h8); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr8: got %h want %h", imem_addr, 32'h8); end
  endtask

  task automatic test_ready_low();
    imem_ready = 1'b0;
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL wait_pc[%0d]: got %h want %h", i, PCF, 32'h8); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, validF); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
    end
    imem_ready = 1'b1;
    StallF = 1'b0;
    tick();
    checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL wait_done_pc: got %h want %h", PCF, 32'hC); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL wait_done_valid: got %b want 1", validF); end
    tick();
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL seq_pc10: got %h want %h", PCF, 32'h10); end
  endtask

  task automatic test_stall();
    StallF = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL hold_pc[%0d]: got %h want %h", i, PCF, 32'h10); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 0", i, validF); end
    end
    StallF = 1'b0;
    tick();
    checks++; if (PCF !== 32'h14) begin errors++; $display("FAIL unhold_pc: got %h want %h", PCF, 32'h14); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL unhold_valid: got %b want 1", validF); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL unhold_req: got %b want 1", imem_req); end
  endtask

  task automatic test_redirect();
    RedirectF = 1'b1;
    RedirectPC = 32'h400;
    StallF = 1'b1;
    tick();
    checks++; if (PCF !== 32'h400) begin errors++; $display("FAIL redir_pc: got %h want %h", PCF, 32'h400); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", validF); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_req: got %b want 1", imem_req); end
    RedirectF = 1'b0;
    StallF = 1'b0;
    tick();
    checks++; if (PCF !== 32'h404) begin errors++; $display("FAIL redir_next_pc: got %h want %h", PCF, 32'h404); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL redir_next_valid: got %b want 1", validF); end
    StallF = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_hold_req: got %b want 0", imem_req); end
    RedirectF = 1'b1;
    RedirectPC = 32'h800;
    tick();
    checks++; if (PCF !== 32'h800) begin errors++; $display("FAIL hold_redir_pc: got %h want %h", PCF, 32'h800); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL hold_redir_valid: got %b want 0", validF); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_redir_req: got %b want 1", imem_req); end
    RedirectF = 1'b0;
    StallF = 1'b0;
    tick();
    checks++; if (PCF !== 32'h804) begin errors++; $display("FAIL hold_redir_next: got %h want %h", PCF, 32'h804); end
  endtask

  task automatic test_reset_in_hold();
    StallF = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_hold_req: got %b want 0", imem_req); end
    reset = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rh_async_pc: got %h want %h", PCF, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_async_req: got %b want 0", imem_req); end
    tick();
    reset = 1'b1;
    StallF = 1'b0;
    tick();
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL rh_boot_valid: got %b want 0", validF); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rh_boot_pc: got %h want %h", PCF, 32'h0); end
    tick();
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL rh_first_pc: got %h want %h", PCF, 32'h4); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL rh_first_valid: got %b want 1", validF); end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    #1;
    checks++; if (w_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_reset_pc: got %h want %h", w_pc, 32'hFFFFFFFC); end
    checks++; if (w_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want %h", w_pc4, 32'h0); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (w_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_boot_pc: got %h want %h", w_pc, 32'hFFFFFFFC); end
    tick();
    checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h want %h", w_pc, 32'h0); end
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", w_valid); end
    checks++; if (w_fault !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b want 0", w_fault); end
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL wrap_main_pc: got %h want %h", PCF, 32'h4); end
  endtask

  task automatic test_misalign();
    RedirectF = 1'b1;
    RedirectPC = 32'h402;
    tick();
    RedirectF = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b want 1", fault); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", imem_req); end
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL mis_pc: got %h want %h", PCF, 32'h4); end
    tick();
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b want 1", fault); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req_sticky: got %b want 0", imem_req); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b want 0", validF); end
    reset = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_reset: got %b want 0", fault); end
    reset = 1'b1;
`else
    checks++; if (PCF !== 32'h400) begin errors++; $display("FAIL mis_pc: got %h want %h", PCF, 32'h400); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_fault: got %b want 0", fault); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b want 0", validF); end
    tick();
    checks++; if (PCF !== 32'h404) begin errors++; $display("FAIL mis_next_pc: got %h want %h", PCF, 32'h404); end
    checks++; if (validF !== 1'b1) begin errors++; $display("FAIL mis_next_valid: got %b want 1", validF); end
`endif
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_ready_low();
    test_stall();
    test_redirect();
    test_reset_in_hold();
    test_wrap();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
